// File: rtl/psum_drain_pkg.sv
// Shared definitions for the column-bottom partial-sum drain: width codes,
// FSM state encoding and the lane-count decode used by the top level.
package psum_drain_pkg;

    localparam logic [3:0] W8 = 4'b1000;
    localparam logic [3:0] W4 = 4'b0100;
    localparam logic [3:0] W2 = 4'b0010;
    localparam logic [3:0] W1 = 4'b0001;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_e;

    // Any code that is not W8/W4 (including illegal ones) is handled in four-lane mode
    function automatic logic [2:0] lane_count(input logic [3:0] width);
        logic [2:0] lanes;
        case (width)
            W8:      lanes = 3'd1;
            W4:      lanes = 3'd2;
            default: lanes = 3'd4;
        endcase
        return lanes;
    endfunction

    function automatic logic width_valid(input logic [3:0] width);
        return (width == W8) || (width == W4) || (width == W2) || (width == W1);
    endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Handshake bundle between the array column, the drain and the writeback path.
// master drives beats and consumes results; slave is the drain itself.
interface psum_drain_if #(
    parameter int COL_WIDTH = 11,
    parameter int ACC_WIDTH = 48
);
    logic [4*COL_WIDTH-1:0] psum_in;
    logic                   psum_valid;
    logic                   psum_ready;
    logic [3:0]             in_width;
    logic                   is_signed;
    logic [7:0]             acc_len;
    logic                   flush;
    logic [4*ACC_WIDTH-1:0] out_data;
    logic [3:0]             out_width;
    logic                   out_valid;
    logic                   out_ready;
    logic                   ovf;
    logic                   cfg_err;

    modport master (
        output psum_in, psum_valid, in_width, is_signed, acc_len, flush, out_ready,
        input  psum_ready, out_data, out_width, out_valid, ovf, cfg_err
    );

    modport slave (
        input  psum_in, psum_valid, in_width, is_signed, acc_len, flush, out_ready,
        output psum_ready, out_data, out_width, out_valid, ovf, cfg_err
    );
endinterface

// File: rtl/psum_drain_fifo.sv
// Small synchronous result FIFO. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; storage resets to zero.
module psum_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign data_o  = mem_q[rdPtr_q];

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Column-bottom partial-sum collector: unpacks beats into 1/2/4 lanes, accumulates
// acc_len beats per lane and queues results. Define PSUM_DRAIN_SAT_EN to saturate on overflow.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int COL_WIDTH = 11,
    parameter int ACC_WIDTH = 48,
    parameter int DEPTH     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    psum_drain_if.slave  bus
);
    localparam int FW = 4 + 4*ACC_WIDTH;

    typedef logic [ACC_WIDTH-1:0] acc_t;

    state_e       state_q, state_d;
    logic [7:0]   count_q, count_d;
    logic [7:0]   len_q, len_d;
    logic [3:0]   width_q, width_d;
    logic         signed_q, signed_d;
    acc_t         acc_q [4];
    acc_t         acc_d [4];
    logic         ovf_q, ovf_d;
    logic         cfgErr_q, cfgErr_d;

    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   accept;
    logic                   push;
    logic [FW-1:0]          pushData;
    logic [FW-1:0]          headData;
    logic [3:0]             curWidth;
    logic                   curSigned;
    logic [7:0]             curLen;
    logic [7:0]             effLen;
    logic [7:0]             nextCount;
    logic [2*COL_WIDTH-1:0] half;
    logic [COL_WIDTH-1:0]   quarter;
    acc_t                   laneExt [4];
    acc_t                   laneSum [4];
    acc_t                   base;
    logic [ACC_WIDTH:0]     wide;
    logic [3:0]             laneOvf;

    assign bus.psum_ready = !fifoFull;
    assign accept         = bus.psum_valid && !fifoFull;

    // The opening beat uses the port configuration; later beats use the latched copy
    always_comb begin
        curWidth  = (state_q == IDLE) ? bus.in_width  : width_q;
        curSigned = (state_q == IDLE) ? bus.is_signed : signed_q;
        curLen    = (state_q == IDLE) ? bus.acc_len   : len_q;
        effLen    = (curLen == 8'd0) ? 8'd1 : curLen;
        nextCount = (state_q == IDLE) ? 8'd1 : count_q + 8'd1;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            laneExt[i] = '0;
        end
        half    = '0;
        quarter = '0;
        case (lane_count(curWidth))
            3'd1: begin
                laneExt[0] = curSigned ? acc_t'($signed(bus.psum_in)) : acc_t'(bus.psum_in);
            end
            3'd2: begin
                for (int i = 0; i < 2; i++) begin
                    half       = bus.psum_in[i*2*COL_WIDTH +: 2*COL_WIDTH];
                    laneExt[i] = curSigned ? acc_t'($signed(half)) : acc_t'(half);
                end
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    quarter    = bus.psum_in[i*COL_WIDTH +: COL_WIDTH];
                    laneExt[i] = curSigned ? acc_t'($signed(quarter)) : acc_t'(quarter);
                end
            end
        endcase
    end

    // Opening beat adds onto zero, which is the same as loading the beat
    always_comb begin
        base = '0;
        wide = '0;
        for (int i = 0; i < 4; i++) begin
            base       = (state_q == IDLE) ? '0 : acc_q[i];
            wide       = {1'b0, base} + {1'b0, laneExt[i]};
            laneOvf[i] = curSigned ? ((base[ACC_WIDTH-1] == laneExt[i][ACC_WIDTH-1]) &&
                                      (wide[ACC_WIDTH-1] != base[ACC_WIDTH-1]))
                                   : wide[ACC_WIDTH];
            laneSum[i] = wide[ACC_WIDTH-1:0];
`ifdef PSUM_DRAIN_SAT_EN
            if (laneOvf[i]) begin
                laneSum[i] = curSigned ? {base[ACC_WIDTH-1], {(ACC_WIDTH-1){~base[ACC_WIDTH-1]}}}
                                       : '1;
            end
`endif
        end
    end

    always_comb begin
        pushData = '0;
        pushData[FW-1 -: 4] = curWidth;
        for (int i = 0; i < 4; i++) begin
            pushData[i*ACC_WIDTH +: ACC_WIDTH] = laneSum[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        width_d  = width_q;
        signed_d = signed_q;
        ovf_d    = ovf_q;
        cfgErr_d = cfgErr_q;
        push     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc_d[i] = acc_q[i];
        end

        if (bus.flush) begin
            state_d = IDLE;
            count_d = '0;
            for (int i = 0; i < 4; i++) begin
                acc_d[i] = '0;
            end
        end else if (accept) begin
            if (state_q == IDLE) begin
                width_d  = bus.in_width;
                signed_d = bus.is_signed;
                len_d    = bus.acc_len;
                cfgErr_d = cfgErr_q | !width_valid(bus.in_width);
            end
            ovf_d = ovf_q | (|laneOvf);
            if (nextCount >= effLen) begin
                push    = 1'b1;
                state_d = IDLE;
                count_d = '0;
                for (int i = 0; i < 4; i++) begin
                    acc_d[i] = '0;
                end
            end else begin
                state_d = ACCUM;
                count_d = nextCount;
                for (int i = 0; i < 4; i++) begin
                    acc_d[i] = laneSum[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            len_q    <= '0;
            width_q  <= '0;
            signed_q <= 1'b0;
            ovf_q    <= 1'b0;
            cfgErr_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            len_q    <= len_d;
            width_q  <= width_d;
            signed_q <= signed_d;
            ovf_q    <= ovf_d;
            cfgErr_q <= cfgErr_d;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    psum_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (pushData),
        .pop_i   (bus.out_ready),
        .data_o  (headData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign bus.out_valid = !fifoEmpty;
    assign bus.out_data  = headData[4*ACC_WIDTH-1:0];
    assign bus.out_width = headData[FW-1 -: 4];
    assign bus.ovf       = ovf_q;
    assign bus.cfg_err   = cfgErr_q;

endmodule
